// File: rtl/camera_pixel_capture_if.sv
// Pixel stream between the camera capture block and its consumer.
// pix_x/pix_y exist only when CAPTURE_PIXEL_COORD_EN is defined.
interface camera_pixel_capture_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
`ifdef CAPTURE_PIXEL_COORD_EN
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

    modport master (
        output pix_data, pix_valid, pix_sof, pix_eol, pix_x, pix_y,
        input  pix_ready
    );
    modport slave (
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_x, pix_y,
        output pix_ready
    );
`else
    modport master (
        output pix_data, pix_valid, pix_sof, pix_eol,
        input  pix_ready
    );
    modport slave (
        input  pix_data, pix_valid, pix_sof, pix_eol,
        output pix_ready
    );
`endif
endinterface

// File: rtl/camera_pixel_capture.sv
// Oversampled DVP camera capture: syncs pclk/href/vsync/data into clk, packs RGB565, buffers in a FWFT FIFO.
// Optional macro CAPTURE_PIXEL_COORD_EN adds per-pixel column/row (pix_x/pix_y) and the row counter.
module camera_pixel_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_done,
    input  logic                          cmos_pclk,
    input  logic                          cmos_href,
    input  logic                          cmos_vsync,
    input  logic [7:0]                    cmos_data,
    camera_pixel_capture_if.master        pix,
    output logic                          overflow,
    output logic [1:0]                    cap_state
);
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_ACTIVE     = 2'd2,
        S_RESYNC     = 2'd3
    } state_t;

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [9:0]  COL_LAST = 10'(H_PIXELS - 1);
`ifdef CAPTURE_PIXEL_COORD_EN
    localparam int          EW       = 37;
`else
    localparam int          EW       = 18;
`endif

    // Every camera line goes through the same two-flop chain so their relative timing is preserved.
    logic [10:0] w_async;
    logic [10:0] r_meta;
    logic [10:0] r_sync;
    logic        r_pclk_q;
    logic        r_href_q;
    logic        r_vsync_q;

    assign w_async = {cmos_pclk, cmos_href, cmos_vsync, cmos_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta    <= '0;
            r_sync    <= '0;
            r_pclk_q  <= 1'b0;
            r_href_q  <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_meta    <= w_async;
            r_sync    <= r_meta;
            r_pclk_q  <= r_sync[10];
            r_href_q  <= r_sync[9];
            r_vsync_q <= r_sync[8];
        end
    end

    logic       w_pclk_rise;
    logic       w_href;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic [7:0] w_byte;

    assign w_pclk_rise = r_sync[10] & ~r_pclk_q;
    assign w_href      = r_sync[9];
    assign w_vs_rise   = r_sync[8] & ~r_vsync_q;
    assign w_vs_fall   = ~r_sync[8] & r_vsync_q;
    assign w_byte      = r_sync[7:0];

    state_t        r_state;
    logic          r_overflow;
    logic          r_phase;
    logic [7:0]    r_hi;
    logic [9:0]    r_col;
    logic          r_sof_pend;
    logic          r_push_vld;
    logic [15:0]   r_push_data;
    logic          r_push_sof;
    logic          r_push_eol;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_drop;
    logic          w_wr;
    logic          w_in_line;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = w_valid & pix.pix_ready;
    assign w_drop    = r_push_vld & w_full & ~w_pop;
    assign w_wr      = r_push_vld & ~w_drop;
    assign w_in_line = cfg_done & (r_state == S_ACTIVE) & ~w_drop & ~w_vs_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_overflow  <= 1'b0;
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_col       <= 10'd0;
            r_sof_pend  <= 1'b0;
            r_push_vld  <= 1'b0;
            r_push_data <= 16'h0000;
            r_push_sof  <= 1'b0;
            r_push_eol  <= 1'b0;
        end else begin
            r_push_vld <= 1'b0;
            if (!cfg_done) begin
                r_state    <= S_IDLE;
                r_overflow <= 1'b0;
                r_phase    <= 1'b0;
                r_col      <= 10'd0;
                r_sof_pend <= 1'b0;
            end else begin
                if (w_drop)
                    r_overflow <= 1'b1;
                case (r_state)
                    S_IDLE:
                        r_state <= S_WAIT_FRAME;
                    S_WAIT_FRAME, S_RESYNC:
                        if (w_vs_fall) begin
                            r_state    <= S_ACTIVE;
                            r_sof_pend <= 1'b1;
                        end
                    S_ACTIVE: begin
                        if (w_drop || w_vs_rise || !w_href) begin
                            // Leaving the line or the frame throws away any half-built pixel.
                            r_phase <= 1'b0;
                            r_col   <= 10'd0;
                            if (w_drop)
                                r_state <= S_RESYNC;
                            else if (w_vs_rise)
                                r_state <= S_WAIT_FRAME;
                        end else if (w_pclk_rise) begin
                            r_phase <= ~r_phase;
                            if (!r_phase) begin
                                r_hi <= w_byte;
                            end else begin
                                r_push_vld  <= 1'b1;
                                r_push_data <= {r_hi, w_byte};
                                r_push_sof  <= r_sof_pend;
                                r_push_eol  <= (r_col == COL_LAST);
                                r_sof_pend  <= 1'b0;
                                if (r_col != COL_LAST)
                                    r_col <= r_col + 10'd1;
                            end
                        end
                    end
                    default:
                        r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

`ifdef CAPTURE_PIXEL_COORD_EN
    localparam logic [8:0] ROW_LAST = 9'(V_LINES - 1);
    logic [8:0] r_row;
    logic       r_line_pix;
    logic [9:0] r_push_x;
    logic [8:0] r_push_y;
    logic       w_href_fall;
    logic       w_enter_active;
    logic       w_form;

    assign w_href_fall    = r_href_q & ~w_href;
    assign w_enter_active = cfg_done & ((r_state == S_WAIT_FRAME) | (r_state == S_RESYNC)) & w_vs_fall;
    assign w_form         = w_in_line & w_href & w_pclk_rise & r_phase;

    // A line only counts toward the row index once it has produced a pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= 9'd0;
            r_line_pix <= 1'b0;
            r_push_x   <= 10'd0;
            r_push_y   <= 9'd0;
        end else if (!cfg_done || w_enter_active) begin
            r_row      <= 9'd0;
            r_line_pix <= 1'b0;
        end else if (w_form) begin
            r_line_pix <= 1'b1;
            r_push_x   <= r_col;
            r_push_y   <= r_row;
        end else if (w_in_line && w_href_fall) begin
            r_line_pix <= 1'b0;
            if (r_line_pix && r_row != ROW_LAST)
                r_row <= r_row + 9'd1;
        end
    end

    assign w_wr_entry = {r_push_y, r_push_x, r_push_sof, r_push_eol, r_push_data};
    assign pix.pix_x  = w_valid ? w_rd_entry[27:18] : 10'd0;
    assign pix.pix_y  = w_valid ? w_rd_entry[36:28] : 9'd0;
`else
    assign w_wr_entry = {r_push_sof, r_push_eol, r_push_data};
`endif

    logic [EW-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // Full with a same-cycle pop writes into the slot being vacated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    assign w_rd_entry    = r_mem[r_rd_ptr];
    assign pix.pix_valid = w_valid;
    assign pix.pix_data  = w_valid ? w_rd_entry[15:0] : 16'h0000;
    assign pix.pix_eol   = w_valid & w_rd_entry[16];
    assign pix.pix_sof   = w_valid & w_rd_entry[17];
    assign overflow      = r_overflow;
    assign cap_state     = r_state;
endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed + randomized bench for camera_pixel_capture against a queue-based pixel model.
// Coordinates are checked as well when CAPTURE_PIXEL_COORD_EN is defined.
module tb_camera_pixel_capture;
    localparam int H = 640;
    localparam int V = 480;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_done;
    logic       cmos_pclk;
    logic       cmos_href;
    logic       cmos_vsync;
    logic [7:0] cmos_data;
    logic       overflow;
    logic [1:0] cap_state;

    camera_pixel_capture_if pix();

    camera_pixel_capture #(.FIFO_DEPTH(D), .H_PIXELS(H), .V_LINES(V)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_done   (cfg_done),
        .cmos_pclk  (cmos_pclk),
        .cmos_href  (cmos_href),
        .cmos_vsync (cmos_vsync),
        .cmos_data  (cmos_data),
        .pix        (pix),
        .overflow   (overflow),
        .cap_state  (cap_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
        logic [9:0]  x;
        logic [8:0]  y;
    } pix_t;

    int         checks   = 0;
    int         failures = 0;
    pix_t       exp_q[$];
    logic [7:0] line_b[$];
    logic       m_sof;
    int         m_row;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Camera side: data set up while pclk is low, pclk period of 8 clk cycles.
    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        cmos_data = b;
        wait_clk(4);
        cmos_pclk = 1'b1;
        if (chk_lat) begin
            wait_clk(3);
            chk("latency_early", 64'(pix.pix_valid), 64'(0));
            wait_clk(1);
            chk("latency_exact", 64'(pix.pix_valid), 64'(1));
        end else begin
            wait_clk(4);
        end
        cmos_pclk = 1'b0;
    endtask

    task automatic drive_line();
        cmos_href = 1'b1;
        wait_clk(8);
        for (int i = 0; i < line_b.size(); i++)
            send_byte(line_b[i], 1'b0);
        wait_clk(4);
        cmos_href = 1'b0;
        wait_clk(16);
    endtask

    task automatic vsync_pulse();
        cmos_vsync = 1'b1;
        wait_clk(20);
        cmos_vsync = 1'b0;
        wait_clk(20);
        m_sof = 1'b1;
        m_row = 0;
    endtask

    task automatic rand_line(input int nbytes);
        line_b.delete();
        for (int i = 0; i < nbytes; i++)
            line_b.push_back(8'($urandom));
    endtask

    // Model: bytes pair up into pixels, trailing odd byte is lost, column saturates at H-1.
    task automatic expect_line();
        int   n;
        int   x;
        pix_t p;
        n = line_b.size() / 2;
        for (int i = 0; i < n; i++) begin
            x     = (i < H - 1) ? i : H - 1;
            p.d   = {line_b[2*i], line_b[2*i+1]};
            p.sof = m_sof;
            p.eol = (x == H - 1);
            p.x   = 10'(x);
            p.y   = 9'(m_row);
            m_sof = 1'b0;
            exp_q.push_back(p);
        end
        if (n > 0 && m_row < V - 1)
            m_row++;
    endtask

    task automatic consume(input int n, input bit rnd, input int budget);
        int   got = 0;
        int   cyc = 0;
        pix_t e;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            pix.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix.pix_valid && pix.pix_ready) begin
                e = exp_q.pop_front();
                chk($sformatf("pixel%0d", got), 64'({pix.pix_data, pix.pix_sof, pix.pix_eol}),
                    64'({e.d, e.sof, e.eol}));
`ifdef CAPTURE_PIXEL_COORD_EN
                chk($sformatf("pixel_xy%0d", got), 64'({pix.pix_x, pix.pix_y}), 64'({e.x, e.y}));
`endif
                got++;
            end
        end
        chk("consume_count", 64'(got), 64'(n));
        @(negedge clk);
        pix.pix_ready = 1'b0;
        chk("no_extra_pixel", 64'(pix.pix_valid), 64'(0));
    endtask

    task automatic run_line(input bit rnd);
        int n;
        expect_line();
        n = exp_q.size();
        fork
            drive_line();
            consume(n, rnd, 30000);
        join
    endtask

    initial begin
        rst           = 1'b1;
        cfg_done      = 1'b0;
        cmos_pclk     = 1'b0;
        cmos_href     = 1'b0;
        cmos_vsync    = 1'b0;
        cmos_data     = 8'h00;
        pix.pix_ready = 1'b0;
        m_sof         = 1'b0;
        m_row         = 0;
        wait_clk(3);
        chk("rst_valid", 64'(pix.pix_valid), 64'(0));
        chk("rst_data", 64'(pix.pix_data), 64'(0));
        chk("rst_sof", 64'(pix.pix_sof), 64'(0));
        chk("rst_eol", 64'(pix.pix_eol), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_state", 64'(cap_state), 64'(0));
        rst = 1'b0;
        wait_clk(2);

        // Unconfigured: camera activity must be ignored.
        vsync_pulse();
        rand_line(8);
        drive_line();
        chk("idle_valid", 64'(pix.pix_valid), 64'(0));
        chk("idle_state", 64'(cap_state), 64'(0));

        cfg_done = 1'b1;
        wait_clk(3);
        chk("wait_frame_state", 64'(cap_state), 64'(1));
        vsync_pulse();
        chk("active_state", 64'(cap_state), 64'(2));

        // Three-byte line: one pixel, exact fill latency, third byte dropped.
        rand_line(3);
        expect_line();
        cmos_href = 1'b1;
        wait_clk(8);
        send_byte(line_b[0], 1'b0);
        send_byte(line_b[1], 1'b1);
        send_byte(line_b[2], 1'b0);
        wait_clk(4);
        cmos_href = 1'b0;
        wait_clk(16);
        chk("odd_line_sof", 64'(pix.pix_sof), 64'(1));
        consume(1, 1'b0, 100);

        // Full-width line of 0x1234.
        vsync_pulse();
        line_b.delete();
        for (int i = 0; i < H; i++) begin
            line_b.push_back(8'h12);
            line_b.push_back(8'h34);
        end
        run_line(1'b0);

        // Random frame with random back-pressure; last line runs past H to exercise saturation.
        vsync_pulse();
        for (int l = 0; l < 3; l++) begin
            rand_line((l == 2) ? 2 * H + $urandom_range(2, 12) : $urandom_range(1, 60));
            run_line(1'b1);
        end
        chk("random_no_overflow", 64'(overflow), 64'(0));

        // Overflow: consumer stalled through a 20-pixel line.
        vsync_pulse();
        pix.pix_ready = 1'b0;
        rand_line(40);
        expect_line();
        while (exp_q.size() > D)
            void'(exp_q.pop_back());
        drive_line();
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_resync_state", 64'(cap_state), 64'(3));
        consume(D, 1'b0, 200);
        chk("ovf_sticky", 64'(overflow), 64'(1));
        vsync_pulse();
        chk("ovf_resume_state", 64'(cap_state), 64'(2));
        rand_line(4);
        run_line(1'b0);

        // Reset in the middle of a line with five pixels buffered.
        vsync_pulse();
        pix.pix_ready = 1'b0;
        rand_line(20);
        cmos_href = 1'b1;
        wait_clk(8);
        for (int i = 0; i < 10; i++)
            send_byte(line_b[i], 1'b0);
        wait_clk(2);
        chk("pre_rst_valid", 64'(pix.pix_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(pix.pix_valid), 64'(0));
        chk("midrst_overflow", 64'(overflow), 64'(0));
        chk("midrst_state", 64'(cap_state), 64'(0));
        wait_clk(1);
        rst = 1'b0;
        for (int i = 10; i < 20; i++)
            send_byte(line_b[i], 1'b0);
        wait_clk(4);
        cmos_href = 1'b0;
        wait_clk(16);
        chk("post_rst_valid", 64'(pix.pix_valid), 64'(0));
        chk("post_rst_state", 64'(cap_state), 64'(1));
        exp_q.delete();
        vsync_pulse();
        rand_line(6);
        run_line(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
